// File: rtl/fa_struct.sv
// rtl/fa_struct.sv - ripple-carry adder built from gate-level full-adder cells, registered result
// One fa_struct_cell per bit; the chain is combinational and only the result register holds state.

module fa_struct_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;
  logic t;

  xor u_xor_p (p, a, b);
  xor u_xor_s (s, p, ci);
  and u_and_g (g, a, b);
  and u_and_t (t, p, ci);
  or  u_or_co (co, g, t);

endmodule

module fa_struct #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_chain;
  logic             ovf_chain;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_struct_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s_chain[i]),
      .co (c[i+1])
    );
  end

  // Carries into and out of the sign bit; for WIDTH=1 this is Cout ^ Cin.
  assign ovf_chain = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= s_chain;
        Cout <= c[WIDTH];
        Ovf  <= ovf_chain;
      end
    end
  end

endmodule

// File: tb/tb_fa_struct.sv
// tb/tb_fa_struct.sv - directed and random checks of fa_struct at WIDTH 1, 4 and 8
`timescale 1ns/100ps

module tb_fa_struct;

  logic clk;
  logic rst;

  logic       v1, c1, ov1, co1, o1;
  logic       a1, b1, s1;
  logic       v4, c4, ov4, co4, o4;
  logic [3:0] a4, b4, s4;
  logic       v8, c8, ov8, co8, o8;
  logic [7:0] a8, b8, s8;

  int passed;
  int total;

  fa_struct #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(c1),
    .out_valid(ov1), .S(s1), .Cout(co1), .Ovf(o1)
  );

  fa_struct #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
    .out_valid(ov4), .S(s4), .Cout(co4), .Ovf(o4)
  );

  fa_struct #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(c8),
    .out_valid(ov8), .S(s8), .Cout(co8), .Ovf(o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    v4 = 1'b1; a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({ov1, s1, co1, o1} !== 4'b0000)
        $display("FAIL reset_w1 cycle %0d: got {ov,S,Cout,Ovf}=%b want 0000", k, {ov1, s1, co1, o1});
      else passed++;
      total++;
      if ({ov4, s4, co4, o4} !== 7'b0)
        $display("FAIL reset_w4 cycle %0d: got %b want 0000000", k, {ov4, s4, co4, o4});
      else passed++;
      total++;
      if ({ov8, s8, co8, o8} !== 11'b0)
        $display("FAIL reset_w8 cycle %0d: got %b want 0", k, {ov8, s8, co8, o8});
      else passed++;
    end
    rst = 1'b0;
    tick();
    // 1+1+0: S=0, Cout=1, Ovf=Cout^Cin=1
    total++;
    if ({ov1, s1, co1, o1} !== 4'b1011)
      $display("FAIL reset_first_result_w1: got %b want 1011", {ov1, s1, co1, o1});
    else passed++;
    total++;
    if ({ov4, s4, co4, o4} !== {1'b1, 4'h2, 1'b0, 1'b0})
      $display("FAIL reset_first_result_w4: got %b want 1001000", {ov4, s4, co4, o4});
    else passed++;
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    tick();
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_s;
    logic [7:0] exp_co;
    logic [2:0] abc;
    exp_s  = 8'b1001_0110;
    exp_co = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      v1 = 1'b1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      tick();
      total++;
      if ({ov1, s1, co1, o1} !== {1'b1, exp_s[i], exp_co[i], exp_co[i] ^ abc[0]})
        $display("FAIL truth_table abc=%b: got {ov,S,Cout,Ovf}=%b want %b", abc,
                 {ov1, s1, co1, o1}, {1'b1, exp_s[i], exp_co[i], exp_co[i] ^ abc[0]});
      else passed++;
    end
    v1 = 1'b0;
    tick();
  endtask

  task automatic test_hold_strobe();
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    tick();
    total++;
    if ({ov1, s1, co1, o1} !== 4'b1100)
      $display("FAIL hold_strobe_load: got %b want 1100", {ov1, s1, co1, o1});
    else passed++;
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({ov1, s1, co1, o1} !== 4'b0100)
        $display("FAIL hold_strobe_hold cycle %0d: got %b want 0100", k, {ov1, s1, co1, o1});
      else passed++;
    end
    a1 = 1'bx; b1 = 1'bz; c1 = 1'bx;
    tick();
    total++;
    if ({ov1, s1, co1, o1} !== 4'b0100)
      $display("FAIL hold_x_inputs: got %b want 0100", {ov1, s1, co1, o1});
    else passed++;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
  endtask

  task automatic test_wide();
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    total++;
    if ({ov4, s4, co4, o4} !== {1'b1, 4'h0, 1'b1, 1'b0})
      $display("FAIL wide_wrap: got %b want 1000010", {ov4, s4, co4, o4});
    else passed++;
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
    tick();
    total++;
    if ({ov4, s4, co4, o4} !== {1'b1, 4'h8, 1'b0, 1'b1})
      $display("FAIL signed_overflow: got %b want 1100001", {ov4, s4, co4, o4});
    else passed++;
    // -8 + -1 = -9 wraps to +7: Cout=1 and signed overflow
    a4 = 4'h8; b4 = 4'hF; c4 = 1'b0;
    tick();
    total++;
    if ({ov4, s4, co4, o4} !== {1'b1, 4'h7, 1'b1, 1'b1})
      $display("FAIL neg_overflow: got %b want 1011111", {ov4, s4, co4, o4});
    else passed++;
    v4 = 1'b0; a4 = 4'hx; b4 = 4'hx; c4 = 1'bx;
    tick();
    total++;
    if ({ov4, s4, co4, o4} !== {1'b0, 4'h7, 1'b1, 1'b1})
      $display("FAIL wide_hold_x: got %b want 0011111", {ov4, s4, co4, o4});
    else passed++;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
  endtask

  task automatic test_mid_reset();
    v8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b1;
    tick();
    total++;
    if ({ov8, s8, co8, o8} !== {1'b1, 8'h31, 1'b0, 1'b0})
      $display("FAIL mid_reset_before: got %h want %h", {ov8, s8, co8, o8}, {1'b1, 8'h31, 1'b0, 1'b0});
    else passed++;
    rst = 1'b1; a8 = 8'h55; b8 = 8'h01;
    tick();
    total++;
    if ({ov8, s8, co8, o8} !== 11'b0)
      $display("FAIL mid_reset_edge: got %h want 0", {ov8, s8, co8, o8});
    else passed++;
    rst = 1'b0; v8 = 1'b0;
    tick();
    total++;
    if ({ov8, s8, co8, o8} !== 11'b0)
      $display("FAIL mid_reset_after: got %h want 0", {ov8, s8, co8, o8});
    else passed++;
    v8 = 1'b1; a8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
    tick();
    total++;
    if ({ov8, s8, co8, o8} !== {1'b1, 8'h80, 1'b0, 1'b1})
      $display("FAIL mid_reset_resume: got %h want %h", {ov8, s8, co8, o8}, {1'b1, 8'h80, 1'b0, 1'b1});
    else passed++;
    v8 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] sum;
    logic       exp_ovf;
    int         bad;
    bad = 0;
    v8 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      sum = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      exp_ovf = (a8[7] == b8[7]) && (sum[7] != a8[7]);
      tick();
      total++;
      if ({ov8, co8, s8, o8} !== {1'b1, sum, exp_ovf}) begin
        bad++;
        if (bad <= 10)
          $display("FAIL random %0d A=%h B=%h Cin=%b: got {ov,Cout,S,Ovf}=%b want %b",
                   k, a8, b8, c8, {ov8, co8, s8, o8}, {1'b1, sum, exp_ovf});
      end else passed++;
    end
    v8 = 1'b0;
    tick();
    total++;
    if (ov8 !== 1'b0)
      $display("FAIL random_tail_out_valid: got %b want 0", ov8);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    v8 = 1'b0; a8 = 8'h0; b8 = 8'h0; c8 = 1'b0;
    #2;
    test_reset();
    test_truth_table();
    test_hold_strobe();
    test_wide();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
